// File: rtl/lfsr_rand_pkg.sv
// Shared types and helpers for the LFSR random source.
//   state_e     : control FSM states (READY, WARM, DRAW)
//   act_width   : index width for an action alphabet (clog2, minimum 1)
//   zero_guard  : replaces an all-zero state with 1 << (width-1)
//   lfsr_step   : one Fibonacci step {fb, state[W-1:1]} followed by the zero guard
//   TAPS_W16 / DEF_SEED_W16 : default tap mask and reset seed for a 16-bit LFSR
// Helpers work on a 32-bit container; callers zero-extend and pass the real width.
package lfsr_rand_pkg;

  typedef enum logic [1:0] {
    READY = 2'd0,
    WARM  = 2'd1,
    DRAW  = 2'd2
  } state_e;

  localparam logic [15:0] TAPS_W16     = 16'h8620;
  localparam logic [15:0] DEF_SEED_W16 = 16'hACE1;

  function automatic int unsigned act_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] zero_guard(input logic [31:0] v,
                                             input int unsigned width);
    logic [31:0] r;
    r = v;
    if (v == '0) r = 32'd1 << (width - 1);
    return r;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input int unsigned width);
    logic        fb;
    logic [31:0] nxt;
    fb  = ^(state & taps);
    nxt = (state >> 1) | ({31'd0, fb} << (width - 1));
    return zero_guard(nxt, width);
  endfunction

endpackage

// File: rtl/lfsr_rand_gen_core.sv
// LFSR state register with step, seed load and zero guard.
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset (state <= DEF_SEED)
//   load_i      : load seed_i this cycle (takes priority over step_i)
//   seed_i      : seed value, zero-guarded on load
//   step_i      : advance the LFSR one step this cycle
//   next_lo_o   : low OUT_W bits of the state the next step would produce
module lfsr_core
  import lfsr_rand_pkg::*;
#(
  parameter int unsigned       WIDTH    = 16,
  parameter int unsigned       OUT_W    = 8,
  parameter logic [WIDTH-1:0]  TAPS     = WIDTH'(TAPS_W16),
  parameter logic [WIDTH-1:0]  DEF_SEED = WIDTH'(DEF_SEED_W16)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             step_i,
  output logic [OUT_W-1:0] next_lo_o
);

  localparam logic [31:0] TAPS_EXT = 32'(TAPS);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] next_full;

  // Guard is folded into the step itself, so the register can never capture 0.
  assign next_full = WIDTH'(lfsr_step(32'(state_q), TAPS_EXT, WIDTH));
  assign next_lo_o = next_full[OUT_W-1:0];

  always_comb begin
    state_d = state_q;
    if (load_i)      state_d = WIDTH'(zero_guard(32'(seed_i), WIDTH));
    else if (step_i) state_d = next_full;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= WIDTH'(zero_guard(32'(DEF_SEED), WIDTH));
    else     state_q <= state_d;
  end

endmodule

// File: rtl/lfsr_rand_gen.sv
// Parametrised Fibonacci LFSR random source with warm-up after seeding and a
// req/valid draw handshake returning a rejection-sampled action index.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   seed_load  : load seed (priority over req; aborts a draw, restarts warm-up)
//   seed       : WIDTH-bit seed value
//   req        : draw request, sampled in READY
//   busy       : high while warming up or drawing
//   valid      : one-cycle pulse, rnd/action/fallback updated
//   rnd        : low OUT_W bits of the state that ended the draw
//   action     : accepted index in [0, NUM_ACTIONS), 0 on fallback
//   fallback   : MAX_TRY candidates rejected, action forced to 0
// Optional (macro LFSR_RAND_EPSILON_EN):
//   epsilon    : OUT_W-bit exploration threshold
//   explore    : registered with valid, (rnd < epsilon)
module lfsr_rand_gen
  import lfsr_rand_pkg::*;
#(
  parameter int unsigned       WIDTH       = 16,
  parameter logic [WIDTH-1:0]  TAPS        = WIDTH'(TAPS_W16),
  parameter int unsigned       OUT_W       = 8,
  parameter int unsigned       NUM_ACTIONS = 4,
  parameter int unsigned       MAX_TRY     = 8,
  parameter int unsigned       WARMUP      = 16,
  parameter logic [WIDTH-1:0]  DEF_SEED    = WIDTH'(DEF_SEED_W16),
  localparam int unsigned      ACT_W       = act_width(NUM_ACTIONS)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] rnd,
  output logic [ACT_W-1:0] action,
  output logic             fallback
`ifdef LFSR_RAND_EPSILON_EN
  ,
  input  logic [OUT_W-1:0] epsilon,
  output logic             explore
`endif
);

  localparam int unsigned       WC_W        = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
  localparam int unsigned       TRY_W       = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
  localparam int unsigned       ACT_X       = ACT_W + 1;
  localparam logic [WC_W-1:0]   WC_INIT     = WC_W'(WARMUP);
  localparam logic [WC_W-1:0]   WC_ONE      = WC_W'(1);
  localparam logic [TRY_W-1:0]  TRY_LAST    = TRY_W'(MAX_TRY - 1);
  localparam logic [TRY_W-1:0]  TRY_ONE     = TRY_W'(1);
  localparam logic [ACT_W:0]    NUM_ACT_EXT = ACT_X'(NUM_ACTIONS);
  localparam state_e            SEED_NEXT   = (WARMUP == 0) ? READY : WARM;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] rnd_q, rnd_d;
  logic [ACT_W-1:0] action_q, action_d;
  logic             fallback_q, fallback_d;

  logic             load, step, publish, in_range;
  logic [OUT_W-1:0] next_lo;
  logic [ACT_W-1:0] cand;

  lfsr_core #(
    .WIDTH    (WIDTH),
    .OUT_W    (OUT_W),
    .TAPS     (TAPS),
    .DEF_SEED (DEF_SEED)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .seed_i    (seed),
    .step_i    (step),
    .next_lo_o (next_lo)
  );

  // Candidate is taken from the state produced by this cycle's step.
  assign cand     = next_lo[ACT_W-1:0];
  assign in_range = ({1'b0, cand} < NUM_ACT_EXT);

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    try_d      = try_q;
    load       = 1'b0;
    step       = 1'b0;
    publish    = 1'b0;
    valid_d    = 1'b0;
    rnd_d      = rnd_q;
    action_d   = action_q;
    fallback_d = fallback_q;

    if (seed_load) begin
      load    = 1'b1;
      state_d = SEED_NEXT;
      wcnt_d  = WC_INIT;
      try_d   = '0;
    end else begin
      unique case (state_q)
        READY: begin
          if (req) begin
            state_d = DRAW;
            try_d   = '0;
          end
        end
        WARM: begin
          step = 1'b1;
          if (wcnt_q == WC_ONE) state_d = READY;
          else                  wcnt_d  = wcnt_q - WC_ONE;
        end
        DRAW: begin
          step = 1'b1;
          if (in_range) begin
            publish    = 1'b1;
            action_d   = cand;
            fallback_d = 1'b0;
            state_d    = READY;
          end else if (try_q == TRY_LAST) begin
            publish    = 1'b1;
            action_d   = '0;
            fallback_d = 1'b1;
            state_d    = READY;
          end else begin
            try_d = try_q + TRY_ONE;
          end
        end
        default: state_d = READY;
      endcase
    end

    if (publish) begin
      valid_d = 1'b1;
      rnd_d   = next_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= READY;
      wcnt_q     <= '0;
      try_q      <= '0;
      valid_q    <= 1'b0;
      rnd_q      <= '0;
      action_q   <= '0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      try_q      <= try_d;
      valid_q    <= valid_d;
      rnd_q      <= rnd_d;
      action_q   <= action_d;
      fallback_q <= fallback_d;
    end
  end

  assign busy     = (state_q != READY);
  assign valid    = valid_q;
  assign rnd      = rnd_q;
  assign action   = action_q;
  assign fallback = fallback_q;

`ifdef LFSR_RAND_EPSILON_EN
  logic explore_q, explore_d;

  always_comb begin
    explore_d = explore_q;
    if (publish) explore_d = (next_lo < epsilon);
  end

  always_ff @(posedge clk) begin
    if (rst) explore_q <= 1'b0;
    else     explore_q <= explore_d;
  end

  assign explore = explore_q;
`endif

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Bench for lfsr_rand_gen: two instances share one stimulus stream.
//   dut_a : defaults (NUM_ACTIONS 4, MAX_TRY 8, WARMUP 16)
//   dut_b : NUM_ACTIONS 3, MAX_TRY 2, WARMUP 0
// A transaction-level model predicts each draw's outcome when it is requested
// and how many cycles the block stays busy; a negedge process compares every cycle.
module tb_lfsr_rand_gen;

  localparam int unsigned TAP_MASK = 32'h8620;
  localparam int unsigned SEED0    = 32'hACE1;

  logic        clk = 1'b0;
  logic        rst, seed_load, req;
  logic [15:0] seed;
  logic [1:0]  busy_w, valid_w, fb_w;
  logic [7:0]  rnd_w [2];
  logic [1:0]  act_w [2];
`ifdef LFSR_RAND_EPSILON_EN
  logic [7:0]  epsilon;
  logic [1:0]  expl_w;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // model state
  int unsigned m_st   [2];
  int unsigned m_left [2];
  bit          m_pend [2];
  int unsigned m_prnd [2];
  int unsigned m_pact [2];
  bit          m_pfb  [2];
  bit          e_valid[2];
  int unsigned e_rnd  [2];
  int unsigned e_act  [2];
  bit          e_fb   [2];
  bit          e_expl [2];

  initial forever #5 clk = ~clk;

  lfsr_rand_gen #(
    .WIDTH(16), .TAPS(16'h8620), .OUT_W(8), .NUM_ACTIONS(4),
    .MAX_TRY(8), .WARMUP(16), .DEF_SEED(16'hACE1)
  ) dut_a (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
    .busy(busy_w[0]), .valid(valid_w[0]), .rnd(rnd_w[0]), .action(act_w[0]),
    .fallback(fb_w[0])
`ifdef LFSR_RAND_EPSILON_EN
    , .epsilon(epsilon), .explore(expl_w[0])
`endif
  );

  lfsr_rand_gen #(
    .WIDTH(16), .TAPS(16'h8620), .OUT_W(8), .NUM_ACTIONS(3),
    .MAX_TRY(2), .WARMUP(0), .DEF_SEED(16'hACE1)
  ) dut_b (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
    .busy(busy_w[1]), .valid(valid_w[1]), .rnd(rnd_w[1]), .action(act_w[1]),
    .fallback(fb_w[1])
`ifdef LFSR_RAND_EPSILON_EN
    , .epsilon(epsilon), .explore(expl_w[1])
`endif
  );

  function automatic int unsigned mstep(input int unsigned s);
    int unsigned p, n;
    p = 0;
    for (int b = 0; b < 16; b++)
      if (((TAP_MASK >> b) & 1) != 0) p = p ^ ((s >> b) & 1);
    n = (s >> 1) + p * 32'h8000;
    return (n == 0) ? 32'h8000 : n;
  endfunction

  function automatic int unsigned mguard(input int unsigned s);
    return (s == 0) ? 32'h8000 : s;
  endfunction

  task automatic model_update(input int i);
    int unsigned na, mt, wu, t;
    na = (i == 0) ? 4 : 3;
    mt = (i == 0) ? 8 : 2;
    wu = (i == 0) ? 16 : 0;
    e_valid[i] = 1'b0;
    if (rst) begin
      m_st[i] = mguard(SEED0); m_left[i] = 0; m_pend[i] = 1'b0;
      e_rnd[i] = 0; e_act[i] = 0; e_fb[i] = 1'b0; e_expl[i] = 1'b0;
    end else if (seed_load) begin
      m_st[i] = mguard(32'(seed));
      for (int k = 0; k < int'(wu); k++) m_st[i] = mstep(m_st[i]);
      m_left[i] = wu;
      m_pend[i] = 1'b0;
    end else if (m_left[i] > 0) begin
      m_left[i] = m_left[i] - 1;
      if (m_left[i] == 0 && m_pend[i]) begin
        m_pend[i]  = 1'b0;
        e_valid[i] = 1'b1;
        e_rnd[i]   = m_prnd[i];
        e_act[i]   = m_pact[i];
        e_fb[i]    = m_pfb[i];
`ifdef LFSR_RAND_EPSILON_EN
        e_expl[i]  = (m_prnd[i] < 32'(epsilon));
`endif
      end
    end else if (req) begin
      // candidate is the state modulo the 4-entry index space; accept below na
      m_pact[i] = 0; m_pfb[i] = 1'b1; t = 0;
      while (t < mt) begin
        m_st[i] = mstep(m_st[i]);
        t++;
        if ((m_st[i] % 4) < na) begin
          m_pact[i] = m_st[i] % 4;
          m_pfb[i]  = 1'b0;
          break;
        end
      end
      m_prnd[i] = m_st[i] % 256;
      m_left[i] = t;
      m_pend[i] = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_update(0);
    model_update(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // per-cycle compare of every output against the model
  initial begin
    logic [13:0] got, want;
    logic        gx;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
`ifdef LFSR_RAND_EPSILON_EN
          gx = expl_w[i];
`else
          gx = 1'b0;
`endif
          got  = {valid_w[i], busy_w[i], fb_w[i], gx, act_w[i], rnd_w[i]};
          want = {e_valid[i], (m_left[i] != 0), e_fb[i], e_expl[i],
                  2'(e_act[i]), 8'(e_rnd[i])};
          tests++;
          if (got !== want) begin
            fails++;
            $display("FAIL cycle dut%0d {valid,busy,fallback,explore,action,rnd}: got %h, want %h (t=%0t)",
                     i, got, want, $time);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed = s; seed_load = 1'b1;
    step_clk();
    seed_load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_w != 2'b00 && n < 100) begin
      step_clk();
      n++;
    end
    check("idle reached", 32'(busy_w), 32'd0);
  endtask

  initial begin
    int n, draws, cyc;
    bit saw_valid;
    rst = 1'b1; seed_load = 1'b0; req = 1'b0; seed = '0;
`ifdef LFSR_RAND_EPSILON_EN
    epsilon = 8'h00;
`endif
    repeat (2) step_clk();
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("reset valid", 32'(valid_w[i]), 32'd0);
      check("reset busy", 32'(busy_w[i]), 32'd0);
      check("reset rnd", 32'(rnd_w[i]), 32'd0);
      check("reset action", 32'(act_w[i]), 32'd0);
      check("reset fallback", 32'(fb_w[i]), 32'd0);
    end
    check("model reset state", m_st[0], 32'hACE1);
    rst = 1'b0;

    // seed 8000, dut_b: first step C000, valid two edges after req
    load_seed(16'h8000);
    check("model seed 8000", m_st[1], 32'h8000);
    req = 1'b1;
    step_clk();
    req = 1'b0;
    check("b valid at req edge", 32'(valid_w[1]), 32'd0);
    check("b busy in draw", 32'(busy_w[1]), 32'd1);
    step_clk();
    check("b valid 2 edges", 32'(valid_w[1]), 32'd1);
    check("b rnd from C000", 32'(rnd_w[1]), 32'h00);
    check("b action from C000", 32'(act_w[1]), 32'd0);
    check("b fallback from C000", 32'(fb_w[1]), 32'd0);
    check("model step 8000", m_st[1], 32'hC000);
    step_clk();
    check("b valid one cycle", 32'(valid_w[1]), 32'd0);
    req = 1'b1;
    step_clk();
    req = 1'b0;
    step_clk();
    check("model step C000", m_st[1], 32'hE000);

    // zero seed and a seed whose next step is zero both land on 8000
    load_seed(16'h0000);
    check("model zero seed", m_st[1], 32'h8000);
    load_seed(16'h0001);
    req = 1'b1;
    step_clk();
    req = 1'b0;
    step_clk();
    check("model guard 0001", m_st[1], 32'h8000);
    check("b rnd guard", 32'(rnd_w[1]), 32'h00);
    check("b valid guard", 32'(valid_w[1]), 32'd1);

    // seed 000E, dut_b: candidates 0007 and 0003 both reject -> fallback
    load_seed(16'h000E);
    req = 1'b1;
    step_clk();
    req = 1'b0;
    step_clk();
    check("b no valid after 1 reject", 32'(valid_w[1]), 32'd0);
    check("b busy after 1 reject", 32'(busy_w[1]), 32'd1);
    step_clk();
    check("b fallback valid", 32'(valid_w[1]), 32'd1);
    check("b fallback flag", 32'(fb_w[1]), 32'd1);
    check("b fallback action", 32'(act_w[1]), 32'd0);
    check("b fallback rnd", 32'(rnd_w[1]), 32'h03);

    // abort both draws with a seed load; dut_a then warms for 16 cycles
    wait_idle();
    load_seed(16'h000E);
    wait_idle();
    req = 1'b1;
    step_clk();
    req = 1'b0;
    load_seed(16'h1234);
    n = 0; saw_valid = 1'b0;
    while (busy_w[0] && n < 40) begin
      if (valid_w != 2'b00) saw_valid = 1'b1;
      n++;
      step_clk();
    end
    check("a warm-up busy cycles", 32'(n), 32'd16);
    check("no valid after abort", 32'(saw_valid), 32'd0);
    repeat (3) begin
      req = 1'b1;
      step_clk();
      req = 1'b0;
      repeat (3) step_clk();
    end

    // reset during warm-up with req held high
    load_seed(16'hBEEF);
    req = 1'b1;
    repeat (2) step_clk();
    rst = 1'b1;
    step_clk();
    check("a busy after rst", 32'(busy_w[0]), 32'd0);
    check("a valid after rst", 32'(valid_w[0]), 32'd0);
    check("b busy after rst", 32'(busy_w[1]), 32'd0);
    check("model rst state", m_st[0], 32'hACE1);
    rst = 1'b0;
    repeat (6) step_clk();

    // randomized run: 10,000 draws on dut_a
    draws = 0; cyc = 0;
    while (draws < 10000 && cyc < 60000) begin
      step_clk();
      cyc++;
`ifdef LFSR_RAND_EPSILON_EN
      for (int i = 0; i < 2; i++) begin
        if (valid_w[i] && epsilon == 8'h80)
          check("explore eps 80", 32'(expl_w[i]), 32'(~rnd_w[i][7]));
        if (valid_w[i] && epsilon == 8'h00)
          check("explore eps 0", 32'(expl_w[i]), 32'd0);
      end
`endif
      if (valid_w[0]) draws++;
      req       = ($urandom_range(0, 9) != 0);
      seed_load = ($urandom_range(0, 299) == 0);
      seed      = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      rst       = ($urandom_range(0, 1999) == 0);
`ifdef LFSR_RAND_EPSILON_EN
      if (draws < 3000)      epsilon = 8'h80;
      else if (draws < 6000) epsilon = 8'h00;
      else                   epsilon = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
`endif
    end
    check("random draw count", 32'(draws), 32'd10000);

    rst = 1'b0; seed_load = 1'b0; req = 1'b0;
    repeat (30) step_clk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
